// File: rtl/evm_pkg.sv
// Shared types and constants for the voting-machine read-out path.
package evm_pkg;

  localparam int unsigned NUM_CAND  = 4;
  localparam logic [6:0]  SEG_BLANK = 7'h00;
  localparam logic [6:0]  SEG_DASH  = 7'h40;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHOW,
    WIN
  } ann_state_t;

  typedef enum logic [1:0] {
    DISP_BLANK,
    DISP_HEX,
    DISP_DASH
  } disp_t;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to seven-segment pattern, segments {g,f,e,d,c,b,a}, active-high.
module seg7_hex_decoder (
  input  logic [3:0] value,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h00;
    case (value)
      4'h0: seg_c = 7'h3F;
      4'h1: seg_c = 7'h06;
      4'h2: seg_c = 7'h5B;
      4'h3: seg_c = 7'h4F;
      4'h4: seg_c = 7'h66;
      4'h5: seg_c = 7'h6D;
      4'h6: seg_c = 7'h7D;
      4'h7: seg_c = 7'h07;
      4'h8: seg_c = 7'h7F;
      4'h9: seg_c = 7'h6F;
      4'hA: seg_c = 7'h77;
      4'hB: seg_c = 7'h7C;
      4'hC: seg_c = 7'h39;
      4'hD: seg_c = 7'h5E;
      4'hE: seg_c = 7'h79;
      4'hF: seg_c = 7'h71;
      default: seg_c = 7'h00;
    endcase
  end

endmodule

// File: rtl/tally_announcer.sv
// Snapshots four tallies, finds the winner (flagging ties) and steps a timed
// announcement across two seven-segment digits.
module tally_announcer
  import evm_pkg::*;
#(
  parameter int unsigned DWELL_TICKS = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] res1,
  input  logic [CNT_W-1:0] res2,
  input  logic [CNT_W-1:0] res3,
  input  logic [CNT_W-1:0] res4,
  output logic             busy,
  output logic             done,
  output logic [2:0]       winner,
  output logic             tie,
  output logic [6:0]       cand_seg,
  output logic [6:0]       count_seg
);

  localparam int unsigned DW_W = $clog2(DWELL_TICKS + 1);

  ann_state_t       state, state_n;
  logic [CNT_W-1:0] snap   [NUM_CAND];
  logic [CNT_W-1:0] snap_n [NUM_CAND];
  logic [CNT_W-1:0] max_r, max_n;
  logic [2:0]       idx, idx_n;
  logic             tie_acc, tie_acc_n;
  logic [1:0]       step, step_n;
  logic [DW_W-1:0]  dwell, dwell_n;
  logic [2:0]       winner_n;
  logic             tie_n, busy_n, done_n;
  logic             take_c;
  disp_t            disp_c;
  logic [3:0]       cand_val_c, count_val_c;
  logic [6:0]       cand_dec_c, count_dec_c;
  logic [6:0]       cand_seg_n, count_seg_n;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < int'(NUM_CAND); i++) snap[i] <= '0;
      max_r     <= '0;
      idx       <= '0;
      tie_acc   <= 1'b0;
      step      <= '0;
      dwell     <= '0;
      winner    <= '0;
      tie       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cand_seg  <= SEG_BLANK;
      count_seg <= SEG_BLANK;
    end else begin
      state     <= state_n;
      snap      <= snap_n;
      max_r     <= max_n;
      idx       <= idx_n;
      tie_acc   <= tie_acc_n;
      step      <= step_n;
      dwell     <= dwell_n;
      winner    <= winner_n;
      tie       <= tie_n;
      busy      <= busy_n;
      done      <= done_n;
      cand_seg  <= cand_seg_n;
      count_seg <= count_seg_n;
    end
  end

  assign take_c = start && !clear && (state == IDLE || state == WIN);

  // Next-state, scan comparison, dwell pacing and next display contents
  always_comb begin
    state_n     = state;
    snap_n      = snap;
    max_n       = max_r;
    idx_n       = idx;
    tie_acc_n   = tie_acc;
    step_n      = step;
    dwell_n     = dwell;
    winner_n    = winner;
    tie_n       = tie;
    busy_n      = busy;
    done_n      = done;
    disp_c      = DISP_BLANK;
    cand_val_c  = 4'h0;
    count_val_c = 4'h0;

    if (clear) begin
      state_n   = IDLE;
      max_n     = '0;
      idx_n     = '0;
      tie_acc_n = 1'b0;
      step_n    = '0;
      dwell_n   = '0;
      winner_n  = '0;
      tie_n     = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
    end else if (take_c) begin
      state_n   = SCAN;
      snap_n[0] = res1;
      snap_n[1] = res2;
      snap_n[2] = res3;
      snap_n[3] = res4;
      max_n     = '0;
      idx_n     = '0;
      tie_acc_n = 1'b0;
      step_n    = '0;
      dwell_n   = '0;
      winner_n  = '0;
      tie_n     = 1'b0;
      busy_n    = 1'b1;
      done_n    = 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (snap[step] > max_r) begin
            max_n     = snap[step];
            idx_n     = 3'(step) + 3'd1;
            tie_acc_n = 1'b0;
          end else if (snap[step] == max_r && max_r != '0) begin
            tie_acc_n = 1'b1;
          end
          if (step == 2'd3) begin
            state_n  = SHOW;
            step_n   = '0;
            dwell_n  = '0;
            tie_n    = tie_acc_n;
            winner_n = (tie_acc_n || max_n == '0) ? 3'd0 : idx_n;
          end else begin
            step_n = step + 2'd1;
          end
        end
        SHOW: begin
          if (tick) begin
            if (dwell == DW_W'(DWELL_TICKS - 1)) begin
              dwell_n = '0;
              if (step == 2'd3) begin
                state_n = WIN;
                busy_n  = 1'b0;
                done_n  = 1'b1;
              end else begin
                step_n = step + 2'd1;
              end
            end else begin
              dwell_n = dwell + DW_W'(1);
            end
          end
        end
        default: ;
      endcase
    end

    // Display follows the state being entered so the digits are registered
    case (state_n)
      SHOW: begin
        disp_c      = DISP_HEX;
        cand_val_c  = 4'(step_n) + 4'd1;
        count_val_c = 4'(snap_n[step_n]);
      end
      WIN: begin
        if (winner_n != 3'd0) begin
          disp_c      = DISP_HEX;
          cand_val_c  = 4'(winner_n);
          count_val_c = 4'(max_n);
        end else begin
          disp_c = DISP_DASH;
        end
      end
      default: disp_c = DISP_BLANK;
    endcase
  end

  seg7_hex_decoder u_cand_dec (
    .value (cand_val_c),
    .seg_c (cand_dec_c)
  );

  seg7_hex_decoder u_count_dec (
    .value (count_val_c),
    .seg_c (count_dec_c)
  );

  assign cand_seg_n  = (disp_c == DISP_HEX)  ? cand_dec_c  :
                       (disp_c == DISP_DASH) ? SEG_DASH    : SEG_BLANK;
  assign count_seg_n = (disp_c == DISP_HEX)  ? count_dec_c :
                       (disp_c == DISP_DASH) ? SEG_DASH    : SEG_BLANK;

endmodule

// File: tb/tb_tally_announcer.sv
// Directed and randomized announcements checked against a max/tie model.
module tb_tally_announcer;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] res1 = '0, res2 = '0, res3 = '0, res4 = '0;
  logic       busy, done, tie;
  logic [2:0] winner;
  logic [6:0] cand_seg, count_seg;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  tally_announcer #(.DWELL_TICKS(DWELL), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .clear(clear),
    .res1(res1), .res2(res2), .res3(res3), .res4(res4),
    .busy(busy), .done(done), .winner(winner), .tie(tie),
    .cand_seg(cand_seg), .count_seg(count_seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner is the unique non-zero maximum; two or more at that maximum is a tie
  task automatic model(input int t[4], output int w, output int ti, output int mx);
    int n;
    mx = 0;
    for (int i = 0; i < 4; i++) if (t[i] > mx) mx = t[i];
    n = 0;
    w = 0;
    for (int i = 0; i < 4; i++) if (t[i] == mx) begin n++; w = i + 1; end
    ti = (mx != 0 && n > 1) ? 1 : 0;
    if (ti == 1 || mx == 0) w = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_winner"}, 32'(winner), 0);
    chk({tag, "_tie"}, 32'(tie), 0);
    chk({tag, "_cand"}, 32'(cand_seg), 32'h00);
    chk({tag, "_count"}, 32'(count_seg), 32'h00);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Full announcement from IDLE or WIN; leaves the DUT in WIN
  task automatic announce(input int t0, input int t1, input int t2, input int t3,
                          input bit mutate);
    int t[4];
    int w, ti, mx;
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    model(t, w, ti, mx);
    res1 = 4'(t0); res2 = 4'(t1); res3 = 4'(t2); res4 = 4'(t3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("scan_busy", 32'(busy), 1);
    chk("scan_done", 32'(done), 0);
    chk("scan_cand", 32'(cand_seg), 32'h00);
    tick = 1'b1;
    repeat (4) @(negedge clk);
    tick = 1'b0;
    for (int s = 0; s < 4; s++) begin
      chk("show_cand", 32'(cand_seg), 32'(hex[s + 1]));
      chk("show_count", 32'(count_seg), 32'(hex[t[s]]));
      if (s == 0) begin
        chk("show_busy", 32'(busy), 1);
        chk("show_done", 32'(done), 0);
        chk("show_winner", 32'(winner), 32'(w));
        chk("show_tie", 32'(tie), 32'(ti));
        if (mutate) begin
          res2 = 4'd9;
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          chk("start_ignored_busy", 32'(busy), 1);
          chk("start_ignored_cand", 32'(cand_seg), 32'(hex[1]));
        end
      end
      for (int j = 0; j < DWELL; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        pulse_tick();
        if (j == DWELL - 2) chk("dwell_hold", 32'(cand_seg), 32'(hex[s + 1]));
      end
    end
    chk("win_busy", 32'(busy), 0);
    chk("win_done", 32'(done), 1);
    chk("win_winner", 32'(winner), 32'(w));
    chk("win_tie", 32'(tie), 32'(ti));
    chk("win_cand", 32'(cand_seg), (w != 0) ? 32'(hex[w]) : 32'h40);
    chk("win_count", 32'(count_seg), (w != 0) ? 32'(hex[mx]) : 32'h40);
    repeat (3) @(negedge clk);
    chk("win_hold", 32'(done), 1);
  endtask

  initial begin
    #12;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("post_reset");

    // Basic run, with res2 changed and a stray start during SHOW
    announce(3, 7, 2, 5, 1'b1);

    // start and clear together in WIN: clear wins
    start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    check_idle("clear_win");
    repeat (2) @(negedge clk);
    check_idle("clear_stays");

    announce(6, 1, 6, 0, 1'b0);
    announce(0, 0, 0, 0, 1'b0);
    announce(1, 2, 3, 15, 1'b0);
    announce(9, 9, 9, 9, 1'b0);

    for (int r = 0; r < 4; r++)
      announce(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);

    // clear mid-SHOW
    res1 = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_idle("clear_show");

    // Asynchronous reset off a clock edge during SHOW
    res1 = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_release");
    announce(int'($urandom_range(0, 15)), 8, 11, int'($urandom_range(0, 15)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tally_announcer.md
# tally_announcer

Read-out counterpart of the vote-capture block in the electronic voting machine. It snapshots the four 4-bit candidate tallies and compares them to find the winner, flagging ties. It then steps through a timed announcement on two seven-segment digits: each candidate's number and count in turn, then the winner. It sits between the vote-capture tallies and the board's display pins, paced by the same slow tick that clocks voting.

## Interface
- `DWELL_TICKS`, default 4: tick pulses each announcement step is held on the display (1..15).
- `CNT_W`, default 4: tally width.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-`clk`-wide pacing pulse from the slow divider.
- `start`  in  1  one-cycle request to begin an announcement.
- `clear`  in  1  one-cycle request to abort and return to idle.
- `res1`..`res4`  in  CNT_W each  live tallies for candidates 1–4.
- `busy`  out  1  high from snapshot until the winner is shown.
- `done`  out  1  high while the winner is being shown.
- `winner`  out  3  winning candidate 1–4; 0 = no winner (all zero, or tie).
- `tie`  out  1  two or more candidates share a non-zero maximum.
- `cand_seg`  out  7  candidate digit, segments {g,f,e,d,c,b,a}, active-high.
- `count_seg`  out  7  count digit, same encoding.

## Operation
- States: IDLE, SCAN, SHOW, WIN.
- IDLE:
  - Both digits blank (7'h00).
  - `start` latches `res1`..`res4` into snapshot registers, clears `max`, `idx`, `tie`, then enters SCAN.
- SCAN: one candidate compared per `clk`, k = 1..4 in order.
  - If snap[k] > max: max ← snap[k], idx ← k, tie ← 0.
  - If snap[k] == max and max != 0: tie ← 1.
  - After k = 4 go to SHOW with step = 1. `winner` ← (tie or max == 0) ? 0 : idx.
- SHOW:
  - `cand_seg` = hex(step), `count_seg` = hex(snap[step]).
  - Step advances after DWELL_TICKS `tick` pulses. After step 4, enter WIN.
- WIN:
  - Valid winner: `cand_seg` = hex(winner), `count_seg` = hex(max).
  - Otherwise both digits show dash (7'h40).
  - Held until `start` (re-snapshot, SCAN) or `clear` (IDLE).
- Tallies are read only at snapshot. Changes to `res*` later have no effect until the next `start`.
- `start` is ignored in SCAN and SHOW. `clear` is honoured in any state and wins over a simultaneous `start`.
- Hex digits 0–F use the standard seven-segment patterns; a tally of 15 shows "F".

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE; `busy`, `done`, `tie` = 0; `winner` = 0; both seg outputs 7'h00.
  - Snapshot, dwell and step counters cleared.
- `start` sampled at edge N:
  - `busy` = 1 from N+1.
  - SCAN occupies N+1..N+4.
  - SHOW step 1 is displayed from N+5.
  - `winner`/`tie` are valid from N+5 and stable until the next snapshot.
- Dwell counter counts `tick` pulses only. `tick` is ignored outside SHOW, so the first step lasts exactly DWELL_TICKS ticks after entry.
- On the `clk` edge with the DWELL_TICKS-th tick of step 4: next cycle is WIN, `busy` = 0, `done` = 1.
- `clear` at edge M: IDLE, all outputs at reset values from M+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `evm_pkg`:
  - `NUM_CAND` = 4.
  - `SEG_BLANK` = 7'h00, `SEG_DASH` = 7'h40.
  - State enum `ann_state_t`.
- Sub-module `seg7_hex_decoder`: 4-bit value to 7-bit pattern. Instantiated twice; its outputs are registered in this block.
- Dwell counter width is clog2(DWELL_TICKS+1); step counter is 2 bits.

## Test plan
- Tallies 3,7,2,5, `start`, DWELL_TICKS = 4:
  - Four steps shown, 1/3, 2/7, 3/2, 4/5, each held 4 ticks.
  - WIN shows 2/7; `winner` = 2, `tie` = 0, `done` = 1.
- Tallies 6,1,6,0 → `tie` = 1, `winner` = 0, WIN digits both 7'h40.
- All tallies 0 → `winner` = 0, `tie` = 0, dashes in WIN. Tally 15 on candidate 4 shows count digit "F".
- Change `res2` from 7 to 9 during SHOW → display and `winner` still reflect the snapshot value 7.
- Second `start` during SHOW ignored. `start` and `clear` in the same cycle during WIN → IDLE, blank digits.
- Deassert `rst_n` mid-SHOW, asynchronously off a clock edge → outputs return to reset values immediately. After release, `start` with new tallies runs a clean announcement.
